ifetch_unit: RTL

Instruction fetch unit sitting between the program counter and the instruction memory port. It accepts fetch addresses from the PC over a valid/ready handshake and issues single-outstanding requests to instruction memory. Returned words are buffered, each with its fetch address, in a small FIFO that feeds decode. A branch/jump redirect flushes every buffered and in-flight fetch, so no stale-path instruction ever reaches decode.

---
 rtl/cpu_pkg.sv | 15 +
 rtl/ifetch_fifo.sv | 54 +++++
 rtl/ifetch_unit.sv | 103 ++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: widths, fetch FSM states and the NOP encoding.
package cpu_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned INST_W = 32;

    localparam logic [31:0] NOP_INST = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } ifetch_state_t;

endpackage

// File: rtl/ifetch_fifo.sv
// Synchronous FIFO of {fetch address, instruction} entries; clear drops everything at the edge.
module ifetch_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DW    = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       clear,
    input  logic [DW-1:0]              din,
    output logic [DW-1:0]              dout,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;

    assign dout = mem[rptr];

    // Clear overrides push and pop; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (clear) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[wptr] <= din;
                wptr      <= wptr + PW'(1);
            end
            if (pop) begin
                rptr <= rptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch: single-outstanding memory requests, returned words buffered for decode, flushable on redirect.
module ifetch_unit #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = cpu_pkg::ADDR_W,
    parameter int unsigned INST_W = cpu_pkg::INST_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pc_valid,
    input  logic [ADDR_W-1:0] pc_addr,
    output logic              pc_ready,
    input  logic              flush,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [INST_W-1:0] mem_rdata,
    output logic              inst_valid,
    output logic [INST_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              inst_ready
);

    import cpu_pkg::*;

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned DW = ADDR_W + INST_W;

    ifetch_state_t     state;
    ifetch_state_t     state_n;
    logic [ADDR_W-1:0] req_addr;
    logic [CW-1:0]     count;
    logic [DW-1:0]     fifo_dout;
    logic              push;
    logic              pop;

    assign mem_addr   = pc_addr;
    assign pc_ready   = mem_req && mem_gnt;
    assign inst_valid = (count != '0);
    assign pop        = inst_valid && inst_ready;
    assign inst       = fifo_dout[INST_W-1:0];
    assign inst_pc    = fifo_dout[DW-1:INST_W];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Requests only leave IDLE, and only with a free FIFO slot, so a return can always be pushed.
    always_comb begin
        state_n = state;
        mem_req = 1'b0;
        push    = 1'b0;
        case (state)
            IDLE: begin
                mem_req = pc_valid && !flush && (count < CW'(DEPTH));
                if (mem_req && mem_gnt) begin
                    state_n = WAIT;
                end
            end
            WAIT: begin
                if (flush) begin
                    state_n = mem_rvalid ? IDLE : DROP;
                end else if (mem_rvalid) begin
                    push    = 1'b1;
                    state_n = IDLE;
                end
            end
            DROP: begin
                if (mem_rvalid) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            req_addr <= '0;
        end else if (pc_ready) begin
            req_addr <= pc_addr;
        end
    end

    ifetch_fifo #(
        .DEPTH (DEPTH),
        .DW    (DW)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .clear (flush),
        .din   ({req_addr, mem_rdata}),
        .dout  (fifo_dout),
        .count (count)
    );

endmodule
